// File: rtl/trigger_network_ctrl_if.sv
// ---------------------------------------------------------------------------
// trigger_network_ctrl_if
//
// Bundles the kernel-control handshake, the per-actor trigger bus and the
// aggregated sleep/sync qualifiers used by trigger_network_ctrl.
//
// Modports:
//   master : the network controller (drives ap_done/ap_ready/ap_idle,
//            trig_start, the aggregates and sync_rounds)
//   slave  : the surrounding kernel control plus the trigger instances
//            (drives ap_start and the per-trigger status vectors)
//
// Signals:
//   ap_start, ap_done, ap_ready, ap_idle : ap_ctrl_hs kernel handshake
//   trig_start     [NUM_ACTORS] : broadcast start to every trigger
//   trig_done      [NUM_ACTORS] : each trigger's ap_done
//   trig_sleep     [NUM_ACTORS] : each trigger's sleep flag
//   trig_sync_exec [NUM_ACTORS] : each trigger's sync_exec flag
//   trig_sync_wait [NUM_ACTORS] : each trigger's sync_wait flag
//   all_sleep, all_sync, all_sync_wait : registered network-wide ANDs
//   sync_rounds    [32]         : completed sync-round count
// ---------------------------------------------------------------------------
interface trigger_network_ctrl_if #(
    parameter int NUM_ACTORS = 4
);
    logic                  ap_start;
    logic                  ap_done;
    logic                  ap_ready;
    logic                  ap_idle;
    logic [NUM_ACTORS-1:0] trig_start;
    logic [NUM_ACTORS-1:0] trig_done;
    logic [NUM_ACTORS-1:0] trig_sleep;
    logic [NUM_ACTORS-1:0] trig_sync_exec;
    logic [NUM_ACTORS-1:0] trig_sync_wait;
    logic                  all_sleep;
    logic                  all_sync;
    logic                  all_sync_wait;
    logic [31:0]           sync_rounds;

    modport master (
        input  ap_start,
        input  trig_done,
        input  trig_sleep,
        input  trig_sync_exec,
        input  trig_sync_wait,
        output ap_done,
        output ap_ready,
        output ap_idle,
        output trig_start,
        output all_sleep,
        output all_sync,
        output all_sync_wait,
        output sync_rounds
    );

    modport slave (
        output ap_start,
        output trig_done,
        output trig_sleep,
        output trig_sync_exec,
        output trig_sync_wait,
        input  ap_done,
        input  ap_ready,
        input  ap_idle,
        input  trig_start,
        input  all_sleep,
        input  all_sync,
        input  all_sync_wait,
        input  sync_rounds
    );
endinterface

// File: rtl/trigger_network_ctrl.sv
// ---------------------------------------------------------------------------
// trigger_network_ctrl
//
// Network-level controller for NUM_ACTORS per-actor trigger FSMs. Accepts the
// kernel start, broadcasts a one-cycle start to all triggers, collects every
// trigger's done into a sticky done_seen mask and reports network completion
// with a one-cycle ap_done/ap_ready pulse. Independently of the FSM it
// registers the network-wide sleep/sync qualifiers every cycle.
//
// Ports:
//   ap_clk : clock
//   ap_rst : asynchronous, active-high reset
//   bus    : trigger_network_ctrl_if.master (handshake, trigger bus,
//            aggregates, sync_rounds)
//
// Parameter:
//   NUM_ACTORS : number of trigger instances (1..64); must match bus.
//
// Build option:
//   TRIGGER_NET_SYNC_COUNT_EN : when defined, sync_rounds counts 0->1 edges
//   of the registered all_sync (cleared in START); otherwise it is tied to 0.
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module trigger_network_ctrl #(
    parameter int NUM_ACTORS = 4
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    trigger_network_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state;
    logic                  ap_idle_q;
    logic                  ap_done_q;
    logic [NUM_ACTORS-1:0] trig_start_q;
    logic [NUM_ACTORS-1:0] done_seen;
    logic [NUM_ACTORS-1:0] done_acc;
    logic                  all_sleep_q;
    logic                  all_sync_q;
    logic                  all_sync_wait_q;

    // Completion includes dones arriving in the same cycle as the check.
    assign done_acc = done_seen | bus.trig_done;

    // -----------------------------------------------------------------------
    // Controller FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state        <= S_IDLE;
            ap_idle_q    <= 1'b1;
            ap_done_q    <= 1'b0;
            trig_start_q <= '0;
            done_seen    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        state        <= S_START;
                        ap_idle_q    <= 1'b0;
                        trig_start_q <= '1;
                    end
                end
                S_START: begin
                    state        <= S_RUN;
                    trig_start_q <= '0;
                    done_seen    <= '0;
                end
                S_RUN: begin
                    // trig_done is only trusted here: idle triggers hold
                    // ap_done high, so it is meaningless in other states.
                    done_seen <= done_acc;
                    if (&done_acc) begin
                        state     <= S_DONE;
                        ap_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    ap_done_q <= 1'b0;
                    ap_idle_q <= 1'b1;
                end
                default: begin
                    state        <= S_IDLE;
                    ap_idle_q    <= 1'b1;
                    ap_done_q    <= 1'b0;
                    trig_start_q <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Aggregates: one register stage so every consumer sees the same value
    // in the same cycle. Computed in every state.
    // -----------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            all_sleep_q     <= 1'b0;
            all_sync_q      <= 1'b0;
            all_sync_wait_q <= 1'b0;
        end else begin
            all_sleep_q     <= &bus.trig_sleep;
            all_sync_q      <= &(bus.trig_sync_exec | bus.trig_sync_wait);
            all_sync_wait_q <= &bus.trig_sync_wait;
        end
    end

`ifdef TRIGGER_NET_SYNC_COUNT_EN
    // -----------------------------------------------------------------------
    // Sync-round counter: counts 0->1 edges of the registered all_sync.
    // A clear in START wins over a coincident increment.
    // -----------------------------------------------------------------------
    logic        all_sync_d;
    logic [31:0] sync_rounds_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            all_sync_d    <= 1'b0;
            sync_rounds_q <= '0;
        end else begin
            all_sync_d <= all_sync_q;
            if (state == S_START) begin
                sync_rounds_q <= '0;
            end else if (all_sync_q && !all_sync_d) begin
                sync_rounds_q <= sync_rounds_q + 32'd1;
            end
        end
    end

    assign bus.sync_rounds = sync_rounds_q;
`else
    assign bus.sync_rounds = '0;
`endif

    assign bus.ap_idle       = ap_idle_q;
    assign bus.ap_done       = ap_done_q;
    assign bus.ap_ready      = ap_done_q;
    assign bus.trig_start    = trig_start_q;
    assign bus.all_sleep     = all_sleep_q;
    assign bus.all_sync      = all_sync_q;
    assign bus.all_sync_wait = all_sync_wait_q;

endmodule

// File: tb/tb_trigger_network_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trigger_network_ctrl
//
// Directed bench for trigger_network_ctrl with NUM_ACTORS = 4: reset values,
// a table of aggregation vectors, and hand-written sequences for the start
// pulse, staggered dones, stale dones, back-to-back starts, the sync-round
// counter and an asynchronous reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_trigger_network_ctrl;

    localparam int N = 4;

`ifdef TRIGGER_NET_SYNC_COUNT_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] sleep;
        logic [N-1:0] sync_exec;
        logic [N-1:0] sync_wait;
        logic         exp_sleep;
        logic         exp_sync;
        logic         exp_sync_wait;
    } agg_vec_t;

    logic ap_clk;
    logic ap_rst;
    int   tests;
    int   fails;

    trigger_network_ctrl_if #(.NUM_ACTORS(N)) bus ();

    trigger_network_ctrl #(.NUM_ACTORS(N)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.master)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ap_idle"},       32'(bus.ap_idle),       32'd1);
        check({tag, " ap_done"},       32'(bus.ap_done),       32'd0);
        check({tag, " ap_ready"},      32'(bus.ap_ready),      32'd0);
        check({tag, " trig_start"},    32'(bus.trig_start),    32'd0);
        check({tag, " all_sleep"},     32'(bus.all_sleep),     32'd0);
        check({tag, " all_sync"},      32'(bus.all_sync),      32'd0);
        check({tag, " all_sync_wait"}, 32'(bus.all_sync_wait), 32'd0);
        check({tag, " sync_rounds"},   bus.sync_rounds,        32'd0);
    endtask

    initial begin
        agg_vec_t vecs [6];
        logic     prev_sleep;
        logic     prev_sync;
        logic     prev_wait;

        vecs[0] = '{4'b1110, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1111, 4'b0011, 4'b1100, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'b0111, 4'b0101, 4'b1000, 1'b0, 1'b0, 1'b0};

        tests              = 0;
        fails              = 0;
        ap_rst             = 1'b1;
        bus.ap_start       = 1'b0;
        bus.trig_done      = '0;
        bus.trig_sleep     = '0;
        bus.trig_sync_exec = '0;
        bus.trig_sync_wait = '0;

        // ---------------- Reset values ----------------
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        ap_rst = 1'b0;
        tick();
        check("post-reset ap_idle", 32'(bus.ap_idle), 32'd1);
        check("post-reset ap_done", 32'(bus.ap_done), 32'd0);

        // ---------------- Basic run, staggered dones ----------------
        bus.ap_start = 1'b1;
        tick();                                   // edge N: IDLE -> START
        check("basic trig_start", 32'(bus.trig_start), 32'hF);
        check("basic ap_idle in START", 32'(bus.ap_idle), 32'd0);
        bus.ap_start = 1'b0;
        tick();                                   // START -> RUN
        check("basic trig_start one cycle", 32'(bus.trig_start), 32'h0);
        bus.trig_done = 4'b0100;
        tick();
        check("basic done after bit2", 32'(bus.ap_done), 32'd0);
        bus.trig_done = 4'b0001;
        tick();
        check("basic done after bit0", 32'(bus.ap_done), 32'd0);
        bus.trig_done = 4'b1000;
        tick();
        check("basic done after bit3", 32'(bus.ap_done), 32'd0);
        check("basic ap_idle in RUN", 32'(bus.ap_idle), 32'd0);
        bus.trig_done = 4'b0010;
        tick();                                   // edge M: RUN -> DONE
        check("basic ap_done", 32'(bus.ap_done), 32'd1);
        check("basic ap_ready", 32'(bus.ap_ready), 32'd1);
        check("basic ap_idle in DONE", 32'(bus.ap_idle), 32'd0);
        bus.trig_done = 4'b0000;
        tick();
        check("basic ap_done one cycle", 32'(bus.ap_done), 32'd0);
        check("basic back to idle", 32'(bus.ap_idle), 32'd1);

        // ---------------- Stale done ignored ----------------
        bus.trig_done = 4'b1111;
        tick();
        check("stale idle no done", 32'(bus.ap_done), 32'd0);
        check("stale stays idle", 32'(bus.ap_idle), 32'd1);
        bus.ap_start = 1'b1;
        tick();                                   // START
        check("stale START no done", 32'(bus.ap_done), 32'd0);
        bus.ap_start = 1'b0;
        tick();                                   // RUN entry
        check("stale RUN entry no done", 32'(bus.ap_done), 32'd0);
        tick();                                   // DONE
        check("stale ap_done after RUN", 32'(bus.ap_done), 32'd1);
        tick();
        check("stale back to idle", 32'(bus.ap_idle), 32'd1);
        check("stale ap_done cleared", 32'(bus.ap_done), 32'd0);
        bus.trig_done = 4'b0000;

        // ---------------- Aggregation table ----------------
        prev_sleep = bus.all_sleep;
        prev_sync  = bus.all_sync;
        prev_wait  = bus.all_sync_wait;
        for (int i = 0; i < 6; i++) begin
            bus.trig_sleep     = vecs[i].sleep;
            bus.trig_sync_exec = vecs[i].sync_exec;
            bus.trig_sync_wait = vecs[i].sync_wait;
            #1;
            // No edge yet: outputs must still show the previous values.
            check($sformatf("agg[%0d] all_sleep hold", i), 32'(bus.all_sleep), 32'(prev_sleep));
            check($sformatf("agg[%0d] all_sync hold", i), 32'(bus.all_sync), 32'(prev_sync));
            tick();
            check($sformatf("agg[%0d] all_sleep", i), 32'(bus.all_sleep), 32'(vecs[i].exp_sleep));
            check($sformatf("agg[%0d] all_sync", i), 32'(bus.all_sync), 32'(vecs[i].exp_sync));
            check($sformatf("agg[%0d] all_sync_wait", i), 32'(bus.all_sync_wait), 32'(vecs[i].exp_sync_wait));
            prev_sleep = vecs[i].exp_sleep;
            prev_sync  = vecs[i].exp_sync;
            prev_wait  = vecs[i].exp_sync_wait;
        end
        bus.trig_sleep     = '0;
        bus.trig_sync_exec = '0;
        bus.trig_sync_wait = '0;
        tick();

        // ---------------- Back-to-back starts ----------------
        bus.trig_done = 4'b1111;
        bus.ap_start  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            // Phases after each edge: START, RUN, DONE, IDLE, repeating.
            check($sformatf("b2b[%0d] trig_start", i), 32'(bus.trig_start),
                  (i % 4 == 0) ? 32'hF : 32'h0);
            check($sformatf("b2b[%0d] ap_done", i), 32'(bus.ap_done),
                  (i % 4 == 2) ? 32'd1 : 32'd0);
            check($sformatf("b2b[%0d] ap_idle", i), 32'(bus.ap_idle),
                  (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        bus.ap_start = 1'b0;
        tick();
        check("b2b settles idle", 32'(bus.ap_idle), 32'd1);
        check("b2b no further start", 32'(bus.trig_start), 32'h0);

        // ---------------- Sync-round counter ----------------
        // A quick run first so START clears the count.
        bus.ap_start = 1'b1;
        tick();
        bus.ap_start = 1'b0;
        tick();
        tick();
        tick();
        check("sync run idle", 32'(bus.ap_idle), 32'd1);
        check("sync cleared by START", bus.sync_rounds, 32'd0);
        for (int r = 0; r < 5; r++) begin
            bus.trig_sync_exec = 4'b1111;
            tick();
            tick();
            bus.trig_sync_exec = 4'b0000;
            tick();
            tick();
            if (r == 0) check("sync after 1 round", bus.sync_rounds, SYNC_EN ? 32'd1 : 32'd0);
        end
        check("sync after 5 rounds", bus.sync_rounds, SYNC_EN ? 32'd5 : 32'd0);
        bus.ap_start = 1'b1;
        tick();
        bus.ap_start = 1'b0;
        tick();
        tick();
        tick();
        check("sync cleared by new START", bus.sync_rounds, 32'd0);
        bus.trig_sync_exec = 4'b1111;
        tick();
        tick();
        check("sync one round after START", bus.sync_rounds, SYNC_EN ? 32'd1 : 32'd0);
        bus.trig_done = 4'b0000;

        // ---------------- Reset mid-RUN ----------------
        bus.trig_sleep     = 4'b1111;
        bus.trig_sync_wait = 4'b1111;
        tick();
        bus.ap_start = 1'b1;
        tick();                                   // START
        bus.ap_start = 1'b0;
        tick();                                   // RUN
        bus.trig_done = 4'b0101;
        tick();                                   // done_seen = 0101
        bus.trig_done = 4'b0000;
        tick();
        check("midrun still running", 32'(bus.ap_idle), 32'd0);
        check("midrun all_sleep before reset", 32'(bus.all_sleep), 32'd1);
        ap_rst = 1'b1;
        #1;                                       // no clock edge in between
        check_reset_outputs("async reset");
        tick();
        check("reset held all_sleep", 32'(bus.all_sleep), 32'd0);
        ap_rst = 1'b0;
        tick();
        bus.ap_start = 1'b1;
        tick();
        check("restart trig_start", 32'(bus.trig_start), 32'hF);
        bus.ap_start = 1'b0;
        tick();
        check("restart trig_start one cycle", 32'(bus.trig_start), 32'h0);
        bus.trig_done = 4'b1010;
        tick();
        bus.trig_done = 4'b0000;
        tick();
        check("restart old done_seen forgotten", 32'(bus.ap_done), 32'd0);
        bus.trig_done = 4'b0101;
        tick();
        check("restart ap_done", 32'(bus.ap_done), 32'd1);
        bus.trig_done = 4'b0000;
        tick();
        check("restart back to idle", 32'(bus.ap_idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trigger_network_ctrl.md
# trigger_network_ctrl

Network-level controller for a group of per-actor trigger FSMs in a Vivado HLS actor network. It takes the kernel start, broadcasts a one-cycle start to every actor trigger, and aggregates each trigger's sleep/sync status into the global `all_sleep`/`all_sync`/`all_sync_wait` qualifiers that drive the sleep/sync protocol. It declares the network done once every trigger has returned to idle. It sits between the top-level kernel control interface and the NUM_ACTORS trigger instances.

## Interface
- `NUM_ACTORS`, default 4: number of trigger instances controlled; legal range 1..64.
- `ap_clk` input 1: clock.
- `ap_rst` input 1: asynchronous, active-high reset.
- `ap_start` input 1: network start request (level, ap_ctrl_hs).
- `ap_done` output 1: one-cycle pulse when the network run completes.
- `ap_ready` output 1: identical to `ap_done`.
- `ap_idle` output 1: high while the controller is in IDLE.
- `trig_start` output NUM_ACTORS: start to each trigger; all bits are equal.
- `trig_done` input NUM_ACTORS: each trigger's `ap_done`.
- `trig_sleep` input NUM_ACTORS: each trigger's `sleep`.
- `trig_sync_exec` input NUM_ACTORS: each trigger's `sync_exec`.
- `trig_sync_wait` input NUM_ACTORS: each trigger's `sync_wait`.
- `all_sleep` output 1: registered AND of `trig_sleep`.
- `all_sync` output 1: registered AND of (`trig_sync_exec` | `trig_sync_wait`) per bit.
- `all_sync_wait` output 1: registered AND of `trig_sync_wait`.
- `sync_rounds` output 32: completed sync-round count (see Configuration).

## Operation
- The controller FSM has four states: IDLE, START, RUN and DONE.
- IDLE → START when `ap_start`=1. Otherwise it stays in IDLE.
- START lasts exactly one cycle.
  - `trig_start` is all-ones.
  - `done_seen[NUM_ACTORS-1:0]` is cleared.
  - The next state is RUN.
- RUN behaviour:
  - `done_seen[i]` is set when `trig_done[i]`=1. It stays set until the next START.
  - RUN → DONE in the cycle after `done_seen` becomes all-ones, including bits set in that same cycle.
  - `trig_done` is ignored in IDLE, START and DONE. This is required because trigger `ap_done` is high while the trigger is idle.
- DONE lasts exactly one cycle.
  - `ap_done`=`ap_ready`=1.
  - The next state is IDLE.
- A new `ap_start` is sampled only in IDLE. If `ap_start` is still high in DONE, it takes effect on the following cycle: DONE→IDLE→START.
- Aggregation:
  - Each aggregate is the AND over all NUM_ACTORS bits, registered once.
  - All consumers see the same value in the same cycle.
  - Aggregates are computed in every state, including IDLE. Idle triggers report sleep and sync_wait high.
- `all_sync_wait`=1 implies `all_sync`=1, by construction.
- NUM_ACTORS=1: each aggregate equals its single input delayed by one cycle.

## Timing
- Reset values:
  - FSM state is IDLE.
  - `ap_idle`=1.
  - `ap_done`=`ap_ready`=0.
  - `trig_start`=0.
  - `all_sleep`=`all_sync`=`all_sync_wait`=0.
  - `done_seen`=0.
  - `sync_rounds`=0.
- Reset asserted mid-run forces all of the above immediately (asynchronously). Operation resumes at the first `ap_clk` edge after deassertion.
- Start latency: `ap_start` sampled high at edge N gives `trig_start` high during cycle N+1 only.
- Aggregate latency: 1 cycle from input change to output change.
- Done latency: the last `trig_done` bit seen at edge M gives `ap_done` high during cycle M+1 to M+2. That is, the RUN→DONE transition happens at edge M and DONE is held for one cycle.
- `ap_idle` is high in IDLE only. It is low from START through DONE.
- `trig_start`, `ap_done`, `ap_idle` and the aggregates all drive directly from flops. There is no combinational path from any input to any output.

## Configuration
- Macro: `TRIGGER_NET_SYNC_COUNT_EN`.
- Defined:
  - `sync_rounds` is a 32-bit counter that increments by 1 on each rising edge of registered `all_sync` (0→1), in any state.
  - It is cleared in START and by reset.
  - It wraps from 0xFFFFFFFF to 0.
- Undefined:
  - The counter logic is absent and `sync_rounds` is tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset mid-RUN:** with NUM_ACTORS=4, assert `ap_rst` while in RUN with `done_seen`=4'b0101 → all outputs show their reset values at once. A later `ap_start` gives a full START pulse, and `done_seen` restarts from 0.
- **Basic run:** pulse `ap_start` → `trig_start`=4'b1111 for exactly one cycle. Then assert `trig_done` in staggered order (bit 2, then 0, then 3, then 1, each one cycle) → exactly one `ap_done`/`ap_ready` pulse, one cycle after bit 1 is seen.
- **Stale done ignored:** hold `trig_done`=4'b1111 through IDLE and START → `done_seen` stays 0 until RUN. Then `ap_done` pulses one cycle after RUN entry (`trig_done` is still high).
- **Aggregation:**
  - `trig_sleep`=4'b1110 → `all_sleep`=0. Setting bit 0 → `all_sleep`=1 one cycle later.
  - `trig_sync_exec`=4'b0011 with `trig_sync_wait`=4'b1100 → `all_sync`=1 and `all_sync_wait`=0.
  - `trig_sync_wait`=4'b1111 → `all_sync_wait`=1.
- **Back-to-back starts:** hold `ap_start`=1 continuously with immediate dones → the sequence repeats START, RUN, DONE, IDLE, START. `ap_idle` is high exactly one cycle per iteration.
- **Macro defined:** toggle `all_sync` inputs 0→1→0 five times, then 0→1 once more after a new START → `sync_rounds` reads 5, then 1. With the macro undefined, `sync_rounds` reads 0 throughout.
